// File: rtl/serial_link_pkg.sv
// Shared constants, frame layout and state type for the bit-banged serial link receiver.
package serial_link_pkg;

  localparam int FRAME_BITS  = 16;
  localparam int DATA_BITS   = 9;
  localparam int SYNC_STAGES = 2;

  localparam int CNT_W = $clog2(FRAME_BITS + 2);

  localparam int START_POS = 0;
  localparam int HDR_LSB   = 1;
  localparam int HDR_MSB   = 3;
  localparam int DATA_LSB  = 4;
  localparam int DATA_MSB  = 12;
  localparam int FTR_LSB   = 13;
  localparam int FTR_MSB   = 14;
  localparam int STOP_POS  = 15;

  localparam logic [2:0] HDR_VAL = 3'b111;
  localparam logic [1:0] FTR_VAL = 2'b11;

  localparam int SCLK_BIT  = 0;
  localparam int SDATA_BIT = 1;
  localparam int CS_N_BIT  = 2;

  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_OVER   = CNT_W'(FRAME_BITS + 1);
  // Cycles spent in HUNT before trusting the synchronised cs_n level (pipeline flush after reset).
  localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2
  } rx_state_e;

  function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
    return (f[START_POS] == 1'b0) && (f[HDR_MSB:HDR_LSB] == HDR_VAL) &&
           (f[FTR_MSB:FTR_LSB] == FTR_VAL) && (f[STOP_POS] == 1'b0);
  endfunction

endpackage

// File: rtl/serial_frame_receiver_sync_edge.sv
// N-flop synchroniser with one history flop; reports level and single-cycle rise/fall.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~hist_q;
  assign fall_o  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/serial_frame_receiver.sv
// Deserialises one LSB-first 16-bit frame per cs_n window, checks framing and hands the
// 9-bit payload to the host through a sticky valid/overrun register.
//
//  state | meaning
//  HUNT  | after reset: wait for sync flush, then for cs_n high (never join a frame mid-stream)
//  IDLE  | link idle, waiting for cs_n fall
//  SHIFT | inside a frame, shifting on sclk rise; cs_n rise ends and evaluates the frame
module serial_frame_receiver
  import serial_link_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 serial_clk,
  input  logic                 serial_data,
  input  logic                 serial_cs_n,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_overrun,
  output logic                 frame_error,
  output logic                 busy
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic sdata_lvl, sdata_rise, sdata_fall;
  logic cs_lvl, cs_rise, cs_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clock(clock), .reset_n(reset_n), .async_i(serial_clk),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdata (
    .clock(clock), .reset_n(reset_n), .async_i(serial_data),
    .level_o(sdata_lvl), .rise_o(sdata_rise), .fall_o(sdata_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clock(clock), .reset_n(reset_n), .async_i(serial_cs_n),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, sclk_fall, sdata_rise, sdata_fall};

  rx_state_e              state_q, state_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ovr_q, ovr_d;
  logic                   err_q, err_d;
  logic                   frame_done;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HUNT;
      shift_q <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    count_d    = count_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    err_d      = 1'b0;
    frame_done = 1'b0;

    if (rx_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      HUNT: begin
        if (count_q != CNT_SETTLE) begin
          count_d = count_q + 1'b1;
        end else if (cs_lvl) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          count_d = '0;
          shift_d = '0;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shift_d = {sdata_lvl, shift_q[FRAME_BITS-1:1]};
          if (count_q != CNT_OVER) count_d = count_q + 1'b1;
        end
        // Evaluated on the post-shift values so a coincident last sclk rise is included.
        if (cs_rise) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase

    if (frame_done) begin
      if ((count_d == CNT_FULL) && frame_ok(shift_d)) begin
        if (!valid_q || rx_ack) begin
          data_d  = shift_d[DATA_MSB:DATA_LSB];
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rx_overrun  = ovr_q;
  assign frame_error = err_q;
  assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: directed scenarios plus randomized frames against a frame-level model.
module tb_serial_frame_receiver;

  logic       clock = 1'b0;
  logic       reset_n, serial_clk, serial_data, serial_cs_n, rx_ack;
  logic [8:0] rx_data;
  logic       rx_valid, rx_overrun, frame_error, busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic [8:0] m_data;
  logic       m_valid, m_ovr;
  int         m_errs = 0;
  int         err_seen = 0;

  serial_frame_receiver dut (
    .clock(clock), .reset_n(reset_n), .serial_clk(serial_clk), .serial_data(serial_data),
    .serial_cs_n(serial_cs_n), .rx_ack(rx_ack), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_overrun(rx_overrun), .frame_error(frame_error), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (frame_error === 1'b1) err_seen++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, run=%0d failed=%0d", tests_run, tests_failed);
    $fatal(1);
  end

  function automatic logic [15:0] make_frame(input logic [8:0] s);
    return {1'b0, 2'b11, s, 3'b111, 1'b0};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_data = b;
    tick(4);
    serial_clk = 1'b1;
    tick(4);
    serial_clk = 1'b0;
  endtask

  // Called one step after the edge at which cs_n was raised; covers the three-edge latency.
  task automatic end_frame(input bit good, input bit bad, input bit ack_c, input logic [8:0] payload);
    logic v_old;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clock); #1;
      if (c == 2) rx_ack = ack_c;
      if (c == 3) begin
        rx_ack = 1'b0;
        v_old = m_valid;
        if (ack_c) begin m_valid = 1'b0; m_ovr = 1'b0; end
        if (good) begin
          if (!v_old || ack_c) begin m_data = payload; m_valid = 1'b1; end
          else m_ovr = 1'b1;
        end
        if (bad) m_errs++;
      end
      @(negedge clock);
      if (c == 2) begin
        tests_run++;
        if (rx_valid !== m_valid || frame_error !== 1'b0) begin
          tests_failed++;
          $display("FAIL early_result: valid=%b err=%b want valid=%b err=0", rx_valid, frame_error, m_valid);
        end
      end
      if (c == 3) begin
        tests_run++;
        if (frame_error !== bad) begin
          tests_failed++;
          $display("FAIL frame_error_pulse: got %b want %b", frame_error, bad);
        end
        tests_run++;
        if (rx_valid !== m_valid || rx_overrun !== m_ovr || (m_valid && rx_data !== m_data)) begin
          tests_failed++;
          $display("FAIL host_reg: data=%h valid=%b ovr=%b want data=%h valid=%b ovr=%b",
                   rx_data, rx_valid, rx_overrun, m_data, m_valid, m_ovr);
        end
        tests_run++;
        if (busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL busy_after_frame: got %b want 0", busy);
        end
      end
      if (c == 4) begin
        tests_run++;
        if (frame_error !== 1'b0 || err_seen != m_errs) begin
          tests_failed++;
          $display("FAIL error_count: err=%b seen=%0d want err=0 seen=%0d", frame_error, err_seen, m_errs);
        end
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic send_frame(input logic [15:0] f, input int n, input bit ack_c, input bit same_edge);
    bit good;
    serial_cs_n = 1'b0;
    tick(4);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_in_frame: got %b want 1", busy);
    end
    for (int i = 0; i < n; i++) begin
      if (same_edge && i == n - 1) begin
        serial_data = f[i % 16];
        tick(4);
        serial_clk  = 1'b1;
        serial_cs_n = 1'b1;
      end else begin
        send_bit(f[i % 16]);
      end
    end
    if (!(same_edge && n > 0)) begin
      tick(4);
      serial_cs_n = 1'b1;
    end
    good = (n == 16) && ((f & 16'hE00F) == 16'h600E);
    end_frame(good, !good, ack_c, f[12:4]);
    serial_clk = 1'b0;
    tick(3);
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(posedge clock); #1;
    rx_ack = 1'b0;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    @(negedge clock);
    tests_run++;
    if (rx_valid !== 1'b0 || rx_overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_clear: valid=%b ovr=%b want 0 0", rx_valid, rx_overrun);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; serial_clk = 1'b0; serial_data = 1'b0; serial_cs_n = 1'b1; rx_ack = 1'b0;
    m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
    tick(3);
    tests_run++;
    if ({rx_data, rx_valid, rx_overrun, frame_error, busy} !== 13'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h want 0", {rx_data, rx_valid, rx_overrun, frame_error, busy});
    end
    reset_n = 1'b1;
    tick(8);
  endtask

  task automatic test_good_frame();
    send_frame(16'h7A5E, 16, 1'b0, 1'b0);
    tests_run++;
    if (rx_data !== 9'h1A5 || rx_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL good_1a5: data=%h valid=%b want 1a5 1", rx_data, rx_valid);
    end
  endtask

  task automatic test_short_frame();
    ack_pulse();
    send_frame(make_frame(9'h0C3), 15, 1'b0, 1'b0);
    tests_run++;
    if (rx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL short_frame_valid: got %b want 0", rx_valid);
    end
    send_frame(16'h0000, 0, 1'b0, 1'b0);
    send_frame(make_frame(9'h0C3), 17, 1'b0, 1'b0);
  endtask

  task automatic test_header_error();
    send_frame(make_frame(9'h12C), 16, 1'b0, 1'b0);
    send_frame(make_frame(9'h0F0) & ~16'h0004, 16, 1'b0, 1'b0);
    tests_run++;
    if (rx_data !== 9'h12C) begin
      tests_failed++;
      $display("FAIL header_error_data: got %h want 12c", rx_data);
    end
  endtask

  task automatic test_overrun();
    ack_pulse();
    send_frame(make_frame(9'h0FF), 16, 1'b0, 1'b0);
    send_frame(make_frame(9'h001), 16, 1'b0, 1'b0);
    tests_run++;
    if (rx_data !== 9'h0FF || rx_overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun: data=%h ovr=%b want 0ff 1", rx_data, rx_overrun);
    end
    ack_pulse();
  endtask

  task automatic test_ack_same_cycle();
    send_frame(make_frame(9'h0FF), 16, 1'b0, 1'b0);
    send_frame(make_frame(9'h001), 16, 1'b1, 1'b0);
    tests_run++;
    if (rx_data !== 9'h001 || rx_valid !== 1'b1 || rx_overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_same_cycle: data=%h valid=%b ovr=%b want 001 1 0", rx_data, rx_valid, rx_overrun);
    end
  endtask

  task automatic test_same_edge();
    ack_pulse();
    send_frame(make_frame(9'h16B), 16, 1'b0, 1'b1);
    tests_run++;
    if (rx_data !== 9'h16B || rx_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_edge_last_bit: data=%h valid=%b want 16b 1", rx_data, rx_valid);
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] f;
    f = make_frame(9'h0AA);
    serial_cs_n = 1'b0;
    tick(4);
    for (int i = 0; i < 7; i++) send_bit(f[i]);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({rx_data, rx_valid, rx_overrun, frame_error, busy} !== 13'h0) begin
      tests_failed++;
      $display("FAIL midframe_reset_outputs: got %h want 0", {rx_data, rx_valid, rx_overrun, frame_error, busy});
    end
    m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
    tick(2);
    reset_n = 1'b1;
    for (int i = 7; i < 16; i++) send_bit(f[i]);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL hunt_ignores_bits: busy=%b want 0", busy);
    end
    tick(4);
    serial_cs_n = 1'b1;
    end_frame(1'b0, 1'b0, 1'b0, 9'h000);
    tick(3);
    send_frame(make_frame(9'h155), 16, 1'b0, 1'b0);
    tests_run++;
    if (rx_data !== 9'h155 || rx_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL after_reset_frame: data=%h valid=%b want 155 1", rx_data, rx_valid);
    end
  endtask

  task automatic test_random();
    logic [15:0] f;
    int n, kind;
    bit ack_c, same;
    int fpos[7] = '{0, 1, 2, 3, 13, 14, 15};
    for (int k = 0; k < 40; k++) begin
      f = make_frame(9'($urandom));
      n = 16;
      kind = $urandom_range(0, 5);
      case (kind)
        3: n = $urandom_range(0, 15);
        4: n = $urandom_range(17, 19);
        5: f[fpos[$urandom_range(0, 6)]] ^= 1'b1;
        default: n = 16;
      endcase
      ack_c = ($urandom_range(0, 3) == 0);
      same  = (n > 0) && ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 4) == 0) ack_pulse();
      send_frame(f, n, ack_c, same);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_short_frame();
    test_header_error();
    test_overrun();
    test_ack_same_cycle();
    test_same_edge();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
